alu_arbiter: RTL and testbench
==============================

ALU_ARBITER -- requirements
Module: alu_arbiter

Interface
REQ-001 SHALL have parameter MUL_LAT, default 3: EXEC cycles for MUL (ctrl 4'b1011); legal 1..15.
REQ-002 SHALL have port clk_i, input, 1: rising-edge clock.
REQ-003 SHALL have port rst_n, input, 1: asynchronous active-low reset.
REQ-004 SHALL have port req_valid_i, input, 2: operation request (bit k = requester k).
REQ-005 SHALL have port req_ready_o, output, 2: grant/accept, one-hot or zero.
REQ-006 SHALL have port req_src1_i, input, 64: {r1,r0} first operands.
REQ-007 SHALL have port req_src2_i, input, 64: {r1,r0} second operands.
REQ-008 SHALL have port req_ctrl_i, input, 8: {r1,r0} 4-bit ALU op codes.
REQ-009 SHALL have port rsp_valid_o, output, 2: result valid to owning requester, one-hot or zero.
REQ-010 SHALL have port rsp_ready_i, input, 2: requester accepts result.
REQ-011 SHALL have port rsp_result_o, output, 32: shared result, meaningful while any rsp_valid_o bit is high.
REQ-012 SHALL have port rsp_zero_o, output, 1: result == 0.
REQ-013 SHALL have port busy_o, output, 1: high whenever state != IDLE.

Function
REQ-014 SHALL implement FSM states IDLE, EXEC, RESP.
REQ-015 IDLE: grant the sole valid requester; if both are valid, grant the one selected by the round-robin pointer prio; req_ready_o driven combinationally, in IDLE only.
REQ-016 Handshake = req_valid_i[g] & req_ready_o[g] at a clock edge.
REQ-017 On handshake, capture src1, src2, ctrl and owner g into registers; load the 4-bit counter with MUL_LAT-1 for MUL, else 0; go to EXEC.
REQ-018 Post-handshake changes on request inputs SHALL have no effect.
REQ-019 Op codes: AND 0000, OR 0001, ADD 0010 (mod 2^32), SUB 0110 (mod 2^32), SLT 0111 (unsigned compare, result 1/0), MUL 1011 (low 32 bits of product). Any other code gives result 0 and zero 1.
REQ-020 EXEC: the counter decrements each cycle; at count 0, register result/zero into response registers and go to RESP.
REQ-021 Latency: with the handshake at edge E, rsp_valid_o rises after edge E+1 for non-MUL ops and after edge E+MUL_LAT for MUL.
REQ-022 RESP: rsp_valid_o[owner]=1; result and zero held stable until rsp_ready_i[owner]=1. On that edge go to IDLE and set prio to the other requester.
REQ-023 rsp_ready_i of the non-owner SHALL be ignored.
REQ-024 No request is accepted outside IDLE: minimum one IDLE cycle between operations, peak throughput one op per 3 cycles.
REQ-025 Both requesters continuously valid SHALL be served in strict alternation.
REQ-026 Dropping req_valid_i before a grant causes no state change.

Reset
REQ-027 Asserting rst_n low immediately forces, in any state including mid-EXEC/RESP: state IDLE, prio 0, counter 0, response registers 0, req_ready_o 00, rsp_valid_o 00, busy_o 0.
REQ-028 An operation in flight at reset is discarded; no response is ever issued for it.
REQ-029 The first grant is possible in the first cycle after rst_n deasserts.

Structure
REQ-030 Shared package alu_pkg SHALL hold the op-code constants (AND/OR/ADD/SUB/SLT/MUL) and the FSM state encoding.
REQ-031 The arithmetic is the single sub-module: the team ALU block, instantiated once and fed only from the captured operand registers.
REQ-032 Target size is 120-400 RTL lines; no other sub-modules.

Verification
REQ-033 r0 only, ADD 5+7 -> req_ready_o=01 in the same cycle; rsp_valid_o=01 two edges later; result 12, zero 0.
REQ-034 Both valid after reset, r0 SUB 3-3, r1 OR 0xF0|0x0F -> r0 served first (result 0, zero 1); r1 served next (result 0xFF); with requests held, grants alternate.
REQ-035 MUL_LAT=3, r1 MUL 0x10000*0x10000 -> rsp_valid_o=10 three edges after the handshake; result 0, zero 1.
REQ-036 rsp_ready_i[owner] held low 5 cycles, rsp_ready_i[other]=1 -> rsp_valid_o/result stable, req_ready_o=00, busy_o=1 throughout; completes only on owner ready.
REQ-037 rst_n low during MUL EXEC -> all outputs 0 immediately; no response after release; a new ADD 1+1 then returns 2.
REQ-038 SLT 0xFFFFFFFF<1 -> result 0; ctrl 4'b1111 -> result 0, zero 1.

Source files
------------

// File: rtl/alu_pkg.sv
`default_nettype none
// ---------------------------------------------------------------------------
// alu_pkg -- op codes and FSM state encoding shared by alu_arbiter. Rev 1.0
// ---------------------------------------------------------------------------
package alu_pkg;

  localparam logic [3:0] OP_AND = 4'b0000;
  localparam logic [3:0] OP_OR  = 4'b0001;
  localparam logic [3:0] OP_ADD = 4'b0010;
  localparam logic [3:0] OP_SUB = 4'b0110;
  localparam logic [3:0] OP_SLT = 4'b0111;
  localparam logic [3:0] OP_MUL = 4'b1011;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_EXEC = 2'd1,
    ST_RESP = 2'd2
  } state_t;

  function automatic logic [1:0] onehot2(input logic idx);
    return idx ? 2'b10 : 2'b01;
  endfunction

endpackage
`default_nettype wire

// File: rtl/alu_arbiter_alu.sv
`default_nettype none
// ---------------------------------------------------------------------------
// alu_arbiter_alu -- combinational 32-bit ALU with zero flag. Rev 1.0
// ---------------------------------------------------------------------------
module alu_arbiter_alu
  import alu_pkg::*;
(
  input  logic [31:0] a_i,
  input  logic [31:0] b_i,
  input  logic [3:0]  op_i,
  output logic [31:0] result_o,
  output logic        zero_o
);

  always_comb begin
    result_o = '0;
    case (op_i)
      OP_AND:  result_o = a_i & b_i;
      OP_OR:   result_o = a_i | b_i;
      OP_ADD:  result_o = a_i + b_i;
      OP_SUB:  result_o = a_i - b_i;
      OP_SLT:  result_o = {31'd0, (a_i < b_i)};
      OP_MUL:  result_o = a_i * b_i;
      default: result_o = '0;
    endcase
  end

  assign zero_o = (result_o == 32'd0);

endmodule
`default_nettype wire

// File: rtl/alu_arbiter.sv
`default_nettype none
// ---------------------------------------------------------------------------
// alu_arbiter -- two-requester round-robin front end for a shared ALU. Rev 1.0
// ---------------------------------------------------------------------------
module alu_arbiter
  import alu_pkg::*;
#(
  parameter int unsigned MUL_LAT = 3
) (
  input  logic        clk_i,
  input  logic        rst_n,
  input  logic [1:0]  req_valid_i,
  output logic [1:0]  req_ready_o,
  input  logic [63:0] req_src1_i,
  input  logic [63:0] req_src2_i,
  input  logic [7:0]  req_ctrl_i,
  output logic [1:0]  rsp_valid_o,
  input  logic [1:0]  rsp_ready_i,
  output logic [31:0] rsp_result_o,
  output logic        rsp_zero_o,
  output logic        busy_o
);

  localparam logic [3:0] MUL_CNT = 4'(MUL_LAT - 1);

  state_t      state_q;
  logic        prio_q;
  logic        owner_q;
  logic [3:0]  cnt_q;
  logic [3:0]  cnt_d;
  logic [31:0] src1_q;
  logic [31:0] src2_q;
  logic [3:0]  ctrl_q;
  logic [31:0] result_q;
  logic        zero_q;
  logic [1:0]  rsp_valid_q;
  logic        busy_q;

  logic [1:0]  grant;
  logic        sel;
  logic        hs;
  logic [3:0]  sel_ctrl;
  logic [31:0] alu_result;
  logic        alu_zero;

  // Grant is gated by rst_n so req_ready_o drops the instant reset asserts.
  always_comb begin
    grant = 2'b00;
    if (rst_n && (state_q == ST_IDLE)) begin
      case (req_valid_i)
        2'b01:   grant = 2'b01;
        2'b10:   grant = 2'b10;
        2'b11:   grant = prio_q ? 2'b10 : 2'b01;
        default: grant = 2'b00;
      endcase
    end
  end

  assign sel      = grant[1];
  assign hs       = |(grant & req_valid_i);
  assign sel_ctrl = sel ? req_ctrl_i[7:4] : req_ctrl_i[3:0];

  always_comb begin
    cnt_d = cnt_q;
    if (hs) begin
      cnt_d = (sel_ctrl == OP_MUL) ? MUL_CNT : 4'd0;
    end else if ((state_q == ST_EXEC) && (cnt_q != 4'd0)) begin
      cnt_d = cnt_q - 4'd1;
    end
  end

  always_ff @(posedge clk_i or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= ST_IDLE;
      prio_q      <= 1'b0;
      owner_q     <= 1'b0;
      cnt_q       <= 4'd0;
      src1_q      <= '0;
      src2_q      <= '0;
      ctrl_q      <= '0;
      result_q    <= '0;
      zero_q      <= 1'b0;
      rsp_valid_q <= 2'b00;
      busy_q      <= 1'b0;
    end else begin
      cnt_q <= cnt_d;
      case (state_q)
        ST_IDLE: begin
          if (hs) begin
            src1_q  <= sel ? req_src1_i[63:32] : req_src1_i[31:0];
            src2_q  <= sel ? req_src2_i[63:32] : req_src2_i[31:0];
            ctrl_q  <= sel_ctrl;
            owner_q <= sel;
            busy_q  <= 1'b1;
            state_q <= ST_EXEC;
          end
        end
        ST_EXEC: begin
          if (cnt_q == 4'd0) begin
            result_q    <= alu_result;
            zero_q      <= alu_zero;
            rsp_valid_q <= onehot2(owner_q);
            state_q     <= ST_RESP;
          end
        end
        ST_RESP: begin
          if (rsp_ready_i[owner_q]) begin
            rsp_valid_q <= 2'b00;
            busy_q      <= 1'b0;
            prio_q      <= ~owner_q;
            state_q     <= ST_IDLE;
          end
        end
        default: begin
          rsp_valid_q <= 2'b00;
          busy_q      <= 1'b0;
          state_q     <= ST_IDLE;
        end
      endcase
    end
  end

  alu_arbiter_alu u_alu (
    .a_i      (src1_q),
    .b_i      (src2_q),
    .op_i     (ctrl_q),
    .result_o (alu_result),
    .zero_o   (alu_zero)
  );

  assign req_ready_o  = grant;
  assign rsp_valid_o  = rsp_valid_q;
  assign rsp_result_o = result_q;
  assign rsp_zero_o   = zero_q;
  assign busy_o       = busy_q;

endmodule
`default_nettype wire

// File: tb/tb_alu_arbiter.sv
`default_nettype none
// ---------------------------------------------------------------------------
// tb_alu_arbiter -- directed and randomized self-checking bench. Rev 1.0
// ---------------------------------------------------------------------------
module tb_alu_arbiter;

  localparam int unsigned MUL_LAT = 3;
  localparam int LAT_MAX = 40;
  localparam logic [3:0] C_AND = 4'b0000;
  localparam logic [3:0] C_OR  = 4'b0001;
  localparam logic [3:0] C_ADD = 4'b0010;
  localparam logic [3:0] C_SUB = 4'b0110;
  localparam logic [3:0] C_SLT = 4'b0111;
  localparam logic [3:0] C_MUL = 4'b1011;

  logic        clk_i = 1'b0;
  logic        rst_n;
  logic [1:0]  req_valid_i;
  logic [1:0]  req_ready_o;
  logic [63:0] req_src1_i;
  logic [63:0] req_src2_i;
  logic [7:0]  req_ctrl_i;
  logic [1:0]  rsp_valid_o;
  logic [1:0]  rsp_ready_i;
  logic [31:0] rsp_result_o;
  logic        rsp_zero_o;
  logic        busy_o;

  int n_checks = 0;
  int n_fail   = 0;
  bit model_prio = 1'b0;

  always #5 clk_i = ~clk_i;

  alu_arbiter #(.MUL_LAT(MUL_LAT)) dut (
    .clk_i        (clk_i),
    .rst_n        (rst_n),
    .req_valid_i  (req_valid_i),
    .req_ready_o  (req_ready_o),
    .req_src1_i   (req_src1_i),
    .req_src2_i   (req_src2_i),
    .req_ctrl_i   (req_ctrl_i),
    .rsp_valid_o  (rsp_valid_o),
    .rsp_ready_i  (rsp_ready_i),
    .rsp_result_o (rsp_result_o),
    .rsp_zero_o   (rsp_zero_o),
    .busy_o       (busy_o)
  );

  // Reference ALU built from plain 64-bit arithmetic: returns {zero, result}.
  function automatic logic [32:0] ref_alu(input logic [3:0] op, input logic [31:0] a,
                                          input logic [31:0] b);
    longint unsigned x, y, r;
    x = 64'(a);
    y = 64'(b);
    case (op)
      C_AND:   r = x & y;
      C_OR:    r = x | y;
      C_ADD:   r = (x + y) % 64'h1_0000_0000;
      C_SUB:   r = (x + 64'h1_0000_0000 - y) % 64'h1_0000_0000;
      C_SLT:   r = (x < y) ? 64'd1 : 64'd0;
      C_MUL:   r = (x * y) % 64'h1_0000_0000;
      default: r = 64'd0;
    endcase
    return {(r == 64'd0), r[31:0]};
  endfunction

  function automatic logic [1:0] exp_grant(input logic [1:0] v);
    if (v == 2'b11) return model_prio ? 2'b10 : 2'b01;
    return v;
  endfunction

  task automatic do_reset();
    @(negedge clk_i);
    req_valid_i = 2'b00;
    rsp_ready_i = 2'b00;
    rst_n = 1'b0;
    repeat (2) @(posedge clk_i);
    #1 rst_n = 1'b1;
    model_prio = 1'b0;
  endtask

  // Issues one request, waits for the response and accepts it after rdly cycles.
  task automatic run_op(input logic [1:0] vld, input logic [63:0] s1, input logic [63:0] s2,
                        input logic [7:0] ct, input bit hold, input int rdly,
                        output logic [1:0] gnt, output int lat, output logic [1:0] rv,
                        output logic [31:0] res, output logic z);
    @(negedge clk_i);
    req_valid_i = vld;
    req_src1_i  = s1;
    req_src2_i  = s2;
    req_ctrl_i  = ct;
    #1 gnt = req_ready_o;
    @(posedge clk_i);
    #1;
    if (!hold) req_valid_i = 2'b00;
    req_src1_i = {$urandom, $urandom};
    req_src2_i = {$urandom, $urandom};
    req_ctrl_i = 8'($urandom);
    lat = 0;
    rv  = 2'b00;
    while (rv == 2'b00 && lat < LAT_MAX) begin
      @(posedge clk_i);
      #1;
      lat++;
      rv = rsp_valid_o;
    end
    res = rsp_result_o;
    z   = rsp_zero_o;
    rsp_ready_i = ~rv;
    repeat (rdly) @(posedge clk_i);
    #1 rsp_ready_i = rv;
    @(posedge clk_i);
    #1 rsp_ready_i = 2'b00;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    req_valid_i = 2'b01;
    rsp_ready_i = 2'b00;
    req_src1_i = '0;
    req_src2_i = '0;
    req_ctrl_i = '0;
    repeat (2) @(negedge clk_i);
    #1;
    n_checks++; if (req_ready_o !== 2'b00) begin n_fail++; $display("FAIL reset_req_ready: got %b expected 00", req_ready_o); end
    n_checks++; if (rsp_valid_o !== 2'b00) begin n_fail++; $display("FAIL reset_rsp_valid: got %b expected 00", rsp_valid_o); end
    n_checks++; if (busy_o !== 1'b0) begin n_fail++; $display("FAIL reset_busy: got %b expected 0", busy_o); end
    n_checks++; if ({rsp_zero_o, rsp_result_o} !== 33'd0) begin n_fail++; $display("FAIL reset_result: got %h/%b expected 0/0", rsp_result_o, rsp_zero_o); end
    req_valid_i = 2'b00;
    @(posedge clk_i);
    #1 rst_n = 1'b1;
    model_prio = 1'b0;
  endtask

  task automatic test_add_single();
    logic [1:0] g, rv; int lat; logic [31:0] res; logic z;
    run_op(2'b01, {32'd0, 32'd5}, {32'd0, 32'd7}, {4'h0, C_ADD}, 1'b0, 0, g, lat, rv, res, z);
    n_checks++; if (g !== 2'b01) begin n_fail++; $display("FAIL add_grant: got %b expected 01", g); end
    n_checks++; if (lat !== 1) begin n_fail++; $display("FAIL add_latency: got %0d expected 1", lat); end
    n_checks++; if (rv !== 2'b01) begin n_fail++; $display("FAIL add_rsp_valid: got %b expected 01", rv); end
    n_checks++; if ({z, res} !== {1'b0, 32'd12}) begin n_fail++; $display("FAIL add_result: got %h/%b expected 0000000c/0", res, z); end
    model_prio = 1'b1;
  endtask

  task automatic test_alternation();
    logic [1:0] g, rv, eg; int lat; logic [31:0] res; logic z; logic [32:0] e;
    logic [63:0] s1, s2; logic [7:0] ct;
    do_reset();
    s1 = {32'h0000_00F0, 32'd3};
    s2 = {32'h0000_000F, 32'd3};
    ct = {C_OR, C_SUB};
    run_op(2'b11, s1, s2, ct, 1'b1, 0, g, lat, rv, res, z);
    n_checks++; if (g !== 2'b01) begin n_fail++; $display("FAIL alt_first_grant: got %b expected 01", g); end
    n_checks++; if ({z, res} !== {1'b1, 32'd0}) begin n_fail++; $display("FAIL alt_sub_result: got %h/%b expected 0/1", res, z); end
    model_prio = 1'b1;
    run_op(2'b11, s1, s2, ct, 1'b1, 0, g, lat, rv, res, z);
    n_checks++; if (g !== 2'b10) begin n_fail++; $display("FAIL alt_second_grant: got %b expected 10", g); end
    n_checks++; if ({z, res} !== {1'b0, 32'hFF}) begin n_fail++; $display("FAIL alt_or_result: got %h/%b expected ff/0", res, z); end
    model_prio = 1'b0;
    for (int i = 0; i < 4; i++) begin
      eg = exp_grant(2'b11);
      e  = eg[1] ? ref_alu(ct[7:4], s1[63:32], s2[63:32]) : ref_alu(ct[3:0], s1[31:0], s2[31:0]);
      run_op(2'b11, s1, s2, ct, 1'b1, i, g, lat, rv, res, z);
      n_checks++; if (g !== eg) begin n_fail++; $display("FAIL alt_loop_grant[%0d]: got %b expected %b", i, g, eg); end
      n_checks++; if ({rv, z, res} !== {eg, e}) begin n_fail++; $display("FAIL alt_loop_rsp[%0d]: got %b %h/%b expected %b %h/%b", i, rv, res, z, eg, e[31:0], e[32]); end
      model_prio = ~eg[1];
    end
    @(negedge clk_i);
    req_valid_i = 2'b00;
  endtask

  task automatic test_mul();
    logic [1:0] g, rv; int lat; logic [31:0] res; logic z;
    run_op(2'b10, {32'h0001_0000, 32'd0}, {32'h0001_0000, 32'd0}, {C_MUL, 4'h0}, 1'b0, 0, g, lat, rv, res, z);
    n_checks++; if (g !== 2'b10) begin n_fail++; $display("FAIL mul_grant: got %b expected 10", g); end
    n_checks++; if (lat !== int'(MUL_LAT)) begin n_fail++; $display("FAIL mul_latency: got %0d expected %0d", lat, MUL_LAT); end
    n_checks++; if (rv !== 2'b10) begin n_fail++; $display("FAIL mul_rsp_valid: got %b expected 10", rv); end
    n_checks++; if ({z, res} !== {1'b1, 32'd0}) begin n_fail++; $display("FAIL mul_result: got %h/%b expected 0/1", res, z); end
    model_prio = 1'b0;
  endtask

  task automatic test_hold();
    int lat;
    @(negedge clk_i);
    req_valid_i = 2'b01;
    req_src1_i  = {32'hDEAD_BEEF, 32'd100};
    req_src2_i  = {32'h1234_5678, 32'd23};
    req_ctrl_i  = {C_ADD, C_SUB};
    @(posedge clk_i);
    #1 req_valid_i = 2'b11;
    lat = 0;
    while (rsp_valid_o == 2'b00 && lat < LAT_MAX) begin
      @(posedge clk_i);
      #1 lat++;
    end
    n_checks++; if ({rsp_valid_o, rsp_result_o} !== {2'b01, 32'd77}) begin n_fail++; $display("FAIL hold_first_rsp: got %b %h expected 01 0000004d", rsp_valid_o, rsp_result_o); end
    rsp_ready_i = 2'b10;
    for (int i = 0; i < 5; i++) begin
      @(posedge clk_i);
      #1;
      n_checks++;
      if ({rsp_valid_o, rsp_result_o, rsp_zero_o, req_ready_o, busy_o} !== {2'b01, 32'd77, 1'b0, 2'b00, 1'b1}) begin
        n_fail++;
        $display("FAIL hold_stable[%0d]: got valid=%b res=%h z=%b rdy=%b busy=%b expected 01 0000004d 0 00 1",
                 i, rsp_valid_o, rsp_result_o, rsp_zero_o, req_ready_o, busy_o);
      end
    end
    rsp_ready_i = 2'b01;
    @(posedge clk_i);
    #1;
    req_valid_i = 2'b00;
    rsp_ready_i = 2'b00;
    n_checks++; if ({rsp_valid_o, busy_o} !== 3'b000) begin n_fail++; $display("FAIL hold_release: got valid=%b busy=%b expected 00 0", rsp_valid_o, busy_o); end
    model_prio = 1'b1;
  endtask

  task automatic test_drop();
    @(negedge clk_i);
    req_valid_i = 2'b10;
    #1;
    n_checks++; if (req_ready_o !== 2'b10) begin n_fail++; $display("FAIL drop_ready: got %b expected 10", req_ready_o); end
    #1 req_valid_i = 2'b00;
    for (int i = 0; i < 3; i++) begin
      @(posedge clk_i);
      #1;
      n_checks++; if ({busy_o, rsp_valid_o} !== 3'b000) begin n_fail++; $display("FAIL drop_idle[%0d]: got busy=%b valid=%b expected 0 00", i, busy_o, rsp_valid_o); end
    end
  endtask

  task automatic test_reset_mid();
    logic [1:0] g, rv; int lat; logic [31:0] res; logic z;
    @(negedge clk_i);
    req_valid_i = 2'b01;
    req_src1_i  = {32'd0, 32'h0001_2345};
    req_src2_i  = {32'd0, 32'h0000_6789};
    req_ctrl_i  = {4'h0, C_MUL};
    @(posedge clk_i);
    #1 req_valid_i = 2'b00;
    @(negedge clk_i);
    rst_n = 1'b0;
    #1;
    n_checks++;
    if ({req_ready_o, rsp_valid_o, busy_o, rsp_result_o, rsp_zero_o} !== 38'd0) begin
      n_fail++;
      $display("FAIL midreset_outputs: got rdy=%b valid=%b busy=%b res=%h z=%b expected all 0",
               req_ready_o, rsp_valid_o, busy_o, rsp_result_o, rsp_zero_o);
    end
    repeat (2) @(posedge clk_i);
    #1 rst_n = 1'b1;
    model_prio = 1'b0;
    for (int i = 0; i < int'(MUL_LAT) + 3; i++) begin
      @(posedge clk_i);
      #1;
      n_checks++; if ({rsp_valid_o, busy_o} !== 3'b000) begin n_fail++; $display("FAIL midreset_ghost[%0d]: got valid=%b busy=%b expected 00 0", i, rsp_valid_o, busy_o); end
    end
    run_op(2'b01, {32'd0, 32'd1}, {32'd0, 32'd1}, {4'h0, C_ADD}, 1'b0, 0, g, lat, rv, res, z);
    n_checks++; if ({g, rv, z, res} !== {2'b01, 2'b01, 1'b0, 32'd2}) begin n_fail++; $display("FAIL midreset_add: got g=%b v=%b %h/%b expected 01 01 00000002/0", g, rv, res, z); end
    model_prio = 1'b1;
  endtask

  task automatic test_slt_illegal();
    logic [1:0] g, rv; int lat; logic [31:0] res; logic z;
    run_op(2'b01, {32'd0, 32'hFFFF_FFFF}, {32'd0, 32'd1}, {4'h0, C_SLT}, 1'b0, 0, g, lat, rv, res, z);
    n_checks++; if ({z, res} !== {1'b1, 32'd0}) begin n_fail++; $display("FAIL slt_big_lt_one: got %h/%b expected 0/1", res, z); end
    run_op(2'b10, {32'd1, 32'd0}, {32'hFFFF_FFFF, 32'd0}, {C_SLT, 4'h0}, 1'b0, 0, g, lat, rv, res, z);
    n_checks++; if ({z, res} !== {1'b0, 32'd1}) begin n_fail++; $display("FAIL slt_one_lt_big: got %h/%b expected 1/0", res, z); end
    run_op(2'b01, {32'd0, 32'h1234_5678}, {32'd0, 32'h0000_00FF}, {4'h0, 4'b1111}, 1'b0, 0, g, lat, rv, res, z);
    n_checks++; if ({z, res} !== {1'b1, 32'd0}) begin n_fail++; $display("FAIL illegal_op: got %h/%b expected 0/1", res, z); end
    n_checks++; if (lat !== 1) begin n_fail++; $display("FAIL illegal_latency: got %0d expected 1", lat); end
    model_prio = 1'b1;
  endtask

  task automatic test_random();
    logic [1:0] g, rv, vld, eg; int lat, elat; logic [31:0] res; logic z; logic [32:0] e;
    logic [63:0] s1, s2; logic [7:0] ct; logic [3:0] op_sel [7];
    op_sel = '{C_AND, C_OR, C_ADD, C_SUB, C_SLT, C_MUL, 4'b0000};
    for (int i = 0; i < 40; i++) begin
      vld = 2'($urandom_range(1, 3));
      for (int k = 0; k < 2; k++) begin
        int p;
        p = $urandom_range(0, 6);
        ct[k*4 +: 4] = (p == 6) ? 4'($urandom) : op_sel[p];
      end
      s1 = {$urandom, $urandom};
      s2 = {$urandom, $urandom};
      if ($urandom_range(0, 3) == 0) begin
        s1 = s1 & 64'h0000_00FF_0000_00FF;
        s2 = s2 & 64'h0000_00FF_0000_00FF;
      end
      eg   = exp_grant(vld);
      e    = eg[1] ? ref_alu(ct[7:4], s1[63:32], s2[63:32]) : ref_alu(ct[3:0], s1[31:0], s2[31:0]);
      elat = ((eg[1] ? ct[7:4] : ct[3:0]) == C_MUL) ? int'(MUL_LAT) : 1;
      run_op(vld, s1, s2, ct, 1'b0, $urandom_range(0, 2), g, lat, rv, res, z);
      n_checks++; if (g !== eg) begin n_fail++; $display("FAIL rand_grant[%0d]: got %b expected %b", i, g, eg); end
      n_checks++; if (lat !== elat) begin n_fail++; $display("FAIL rand_latency[%0d]: got %0d expected %0d", i, lat, elat); end
      n_checks++; if (rv !== eg) begin n_fail++; $display("FAIL rand_rsp_valid[%0d]: got %b expected %b", i, rv, eg); end
      n_checks++; if ({z, res} !== e) begin n_fail++; $display("FAIL rand_result[%0d]: got %h/%b expected %h/%b", i, res, z, e[31:0], e[32]); end
      model_prio = ~eg[1];
    end
  endtask

  initial begin
    test_reset();
    test_add_single();
    test_alternation();
    test_mul();
    test_hold();
    test_drop();
    test_reset_mid();
    test_slt_illegal();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #300000;
    $display("FAIL watchdog: simulation time limit reached, checks=%0d failures=%0d", n_checks, n_fail);
    $fatal(1, "watchdog expired");
  end

endmodule
`default_nettype wire
